// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full adder; the only arithmetic cell in the serial adder's carry loop.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through full_adder_1b.
// Define SERIAL_ADDER_SUB_MODE_EN to add the `sub` port (A - B in two's complement).
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output state_t           state_dbg
);

    // Handshake: start is a request taken only while busy is low (IDLE); once taken,
    // the block ignores start until it returns to IDLE. done pulses for exactly one
    // cycle and Sum/Cout stay valid from that cycle until the next accepted start.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  opa, opb;
    logic              carry;
    logic [CW-1:0]     count;
    logic              fa_s, fa_cout;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

`ifdef SERIAL_ADDER_SUB_MODE_EN
    // Subtraction is A + ~B + 1, so Cin is overridden rather than combined.
    assign b_load     = sub ? ~B : B;
    assign carry_load = sub ? 1'b1 : Cin;
`else
    assign b_load     = B;
    assign carry_load = Cin;
`endif

    full_adder_1b u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            count <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Sum/Cout deliberately survive acceptance; they only shift in SHIFT.
                    if (start) begin
                        opa   <= A;
                        opb   <= b_load;
                        carry <= carry_load;
                        count <= '0;
                    end
                end
                ST_SHIFT: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_cout;
                    Sum   <= {fa_s, Sum[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        Cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: randomized and directed operations against an
// arithmetic reference model; covers latency, busy rejection, async reset and back-to-back.
module tb_serial_adder_fsm;
    import serial_adder_pkg::*;

    localparam int W = 8;
    localparam int DONE_LAT = W + 1;
    localparam int MAX_WAIT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_MODE_EN
    logic         sub;
`endif
    logic         busy, done, cout;
    logic [W-1:0] sum;
    state_t       state_dbg;

    int checks = 0;
    int failures = 0;

    logic [W:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (op_a),
        .B         (op_b),
        .Cin       (cin),
`ifdef SERIAL_ADDER_SUB_MODE_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .Sum       (sum),
        .Cout      (cout),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model ----------------
    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
        int unsigned total;
        total = int'(a) + int'(b) + int'(c);
        return (W+1)'(total);
    endfunction

    function automatic logic [W:0] model_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] diff;
        diff = W'(int'(a) - int'(b));
        return {(a >= b), diff};
    endfunction

    // ---------------- driver ----------------
    // Issues one single-cycle start and waits (bounded) for done; returns the cycle index
    // of done relative to acceptance, with the result sampled in that cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output logic [W-1:0] s, output logic co);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        s  = sum;
        co = cout;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        #2;
        checks++;
        if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all zero",
                     busy, done, cout, sum);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[3] = '{8'h3C, 8'hFF, 8'hFF};
        logic [W-1:0] tb_[3] = '{8'h42, 8'h01, 8'h00};
        logic         tc[3] = '{1'b0, 1'b0, 1'b1};
        int lat;
        logic [W-1:0] s;
        logic co;
        logic [W:0] exp;
        for (int i = 0; i < 3; i++) begin
            exp = model_add(ta[i], tb_[i], tc[i]);
            run_op(ta[i], tb_[i], tc[i], lat, s, co);
            checks++;
            if (lat !== DONE_LAT) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, DONE_LAT);
            end
            checks++;
            if ({co, s} !== exp) begin
                failures++;
                $display("FAIL directed_result[%0d]: got cout=%b sum=%h, want cout=%b sum=%h",
                         i, co, s, exp[W], exp[W-1:0]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
                failures++;
                $display("FAIL directed_hold[%0d]: got done=%b busy=%b cout=%b sum=%h, want 0 0 %b %h",
                         i, done, busy, cout, sum, exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        logic [W:0] exp;
        exp = model_add(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        op_a  = 8'h01;
        op_b  = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        op_a  = 8'h11;
        op_b  = 8'h22;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== DONE_LAT || {cout, sum} !== exp) begin
            failures++;
            $display("FAIL busy_ignore: got lat=%0d cout=%b sum=%h, want lat=%0d cout=%b sum=%h",
                     lat, cout, sum, DONE_LAT, exp[W], exp[W-1:0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || {cout, sum} !== exp) begin
            failures++;
            $display("FAIL busy_no_restart: got busy=%b sum=%h, want busy=0 sum=%h",
                     busy, sum, exp[W-1:0]);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        logic [W-1:0] s;
        logic co;
        logic [W:0] exp;
        @(negedge clk);
        op_a  = 8'hA7;
        op_b  = 8'h5E;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            failures++;
            $display("FAIL midreset_async: got busy=%b done=%b cout=%b sum=%h, want all zero",
                     busy, done, cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        exp = model_add(8'h5A, 8'h33, 1'b1);
        run_op(8'h5A, 8'h33, 1'b1, lat, s, co);
        checks++;
        if (lat !== DONE_LAT || {co, s} !== exp) begin
            failures++;
            $display("FAIL midreset_recover: got lat=%0d cout=%b sum=%h, want lat=%0d cout=%b sum=%h",
                     lat, co, s, DONE_LAT, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int ndone = 0;
        int waited = 0;
        logic [W:0] exp;
        exp = model_add(8'h80, 8'h80, 1'b0);
        @(negedge clk);
        op_a  = 8'h80;
        op_b  = 8'h80;
        cin   = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if ({cout, sum} !== exp) begin
                    failures++;
                    $display("FAIL b2b_result: got cout=%b sum=%h, want cout=%b sum=%h",
                             cout, sum, exp[W], exp[W-1:0]);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last !== DONE_LAT + 1) begin
                        failures++;
                        $display("FAIL b2b_period: got %0d, want %0d", c - last, DONE_LAT + 1);
                    end
                end
                last = c;
                ndone++;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", ndone);
        end
        while (busy && waited < MAX_WAIT) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got busy=%b after %0d cycles, want 0", busy, waited);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] s, ra, rb;
        logic co, rc;
        logic [W:0] exp;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rc = 1'($urandom_range(0, 1));
            exp_q.push_back(model_add(ra, rb, rc));
            run_op(ra, rb, rc, lat, s, co);
            exp = exp_q.pop_front();
            checks++;
            if (lat !== DONE_LAT || {co, s} !== exp) begin
                failures++;
                $display("FAIL random[%0d]: a=%h b=%h cin=%b got lat=%0d cout=%b sum=%h, want lat=%0d cout=%b sum=%h",
                         i, ra, rb, rc, lat, co, s, DONE_LAT, exp[W], exp[W-1:0]);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_MODE_EN
    task automatic test_sub();
        logic [W-1:0] ta[2] = '{8'h05, 8'h07};
        logic [W-1:0] tb_[2] = '{8'h07, 8'h05};
        int lat;
        logic [W-1:0] s, ra, rb;
        logic co;
        logic [W:0] exp;
        sub = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 2) begin
                ra = ta[i];
                rb = tb_[i];
            end else begin
                ra = W'($urandom_range(0, (1 << W) - 1));
                rb = W'($urandom_range(0, (1 << W) - 1));
            end
            exp = model_sub(ra, rb);
            run_op(ra, rb, 1'($urandom_range(0, 1)), lat, s, co);
            checks++;
            if (lat !== DONE_LAT || {co, s} !== exp) begin
                failures++;
                $display("FAIL sub[%0d]: a=%h b=%h got lat=%0d cout=%b diff=%h, want lat=%0d cout=%b diff=%h",
                         i, ra, rb, lat, co, s, DONE_LAT, exp[W], exp[W-1:0]);
            end
        end
        sub = 1'b0;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
`ifdef SERIAL_ADDER_SUB_MODE_EN
        sub = 1'b0;
`endif
        test_reset();
        test_directed();
        test_ignore_busy();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADDER_SUB_MODE_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
